spkr_dac_spi_writer: RTL

Four-channel SPI DAC writer directly downstream of the speaker inverter. It latches the four inverted 12-bit speaker samples on a start strobe and serialises each one as a 16-bit SPI frame to the quad speaker DAC. Optionally, it pulses a shared LDAC line so all four outputs update together. It is the last digital stage before the analog speaker drivers.

---
 rtl/spkr_pkg.sv | 31 +++
 rtl/spkr_spi_shifter.sv | 59 +++++
 rtl/spkr_dac_spi_writer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spkr_pkg.sv
// Shared definitions for the speaker DAC SPI writer: widths, frame config bits, channel ids and FSM states.
package spkr_pkg;

    localparam int SPKR_SAMPLE_W = 12;
    localparam int SPKR_FRAME_W  = 16;

    localparam logic SPKR_CFG_BUF    = 1'b0;
    localparam logic SPKR_CFG_SHDN_N = 1'b1;

    localparam logic [1:0] SPKR_CH_A = 2'd0;
    localparam logic [1:0] SPKR_CH_B = 2'd1;
    localparam logic [1:0] SPKR_CH_C = 2'd2;
    localparam logic [1:0] SPKR_CH_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_LDAC  = 3'd4,
        ST_FIN   = 3'd5
    } spkr_state_e;

    function automatic logic [SPKR_FRAME_W-1:0] spkr_frame(
        input logic [1:0]               ch,
        input logic [SPKR_SAMPLE_W-1:0] sample
    );
        return {ch, SPKR_CFG_BUF, SPKR_CFG_SHDN_N, sample};
    endfunction

endpackage

// File: rtl/spkr_spi_shifter.sv
// SPI mode-0 serialiser: loads a 16-bit frame, emits sclk every CLK_DIV clk cycles per half-period,
// shifts mosi on sclk falling edges and flags the cycle of the final sclk fall with frame_done.
module spkr_spi_shifter
    import spkr_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [SPKR_FRAME_W-1:0] frame,
    output logic                    sclk,
    output logic                    mosi,
    output logic                    frame_done
);

    logic [SPKR_FRAME_W-1:0] shreg_r;
    logic [15:0]             div_r;
    logic [4:0]              half_r;
    logic                    active_r;
    logic                    sclk_r;
    logic                    tick_s;

    assign tick_s     = active_r && (div_r == 16'(CLK_DIV - 1));
    assign frame_done = tick_s && (half_r == 5'd31);
    assign sclk       = sclk_r;
    assign mosi       = shreg_r[SPKR_FRAME_W-1];

    // Half-period divider, sclk toggle and MSB-first shift on falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r  <= '0;
            div_r    <= 16'd0;
            half_r   <= 5'd0;
            active_r <= 1'b0;
            sclk_r   <= 1'b0;
        end else if (load) begin
            shreg_r  <= frame;
            div_r    <= 16'd0;
            half_r   <= 5'd0;
            active_r <= 1'b1;
            sclk_r   <= 1'b0;
        end else if (tick_s) begin
            div_r  <= 16'd0;
            half_r <= half_r + 5'd1;
            sclk_r <= ~sclk_r;
            // the last fall leaves bit 0 on the line; nothing follows it
            if (sclk_r && (half_r != 5'd31)) begin
                shreg_r <= {shreg_r[SPKR_FRAME_W-2:0], 1'b0};
            end
            if (half_r == 5'd31) begin
                active_r <= 1'b0;
            end
        end else if (active_r) begin
            div_r <= div_r + 16'd1;
        end
    end

endmodule

// File: rtl/spkr_dac_spi_writer.sv
// Quad speaker DAC writer: latches four samples on start and sends one 16-bit SPI frame per channel.
// Define SPKR_DAC_LDAC_EN to pulse ldac_n after the last frame so all channels update together.
module spkr_dac_spi_writer
    import spkr_pkg::*;
#(
    parameter int CLK_DIV        = 1,
    parameter int CS_HIGH_CYCLES = 2,
    parameter int LDAC_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] data_a,
    input  logic [11:0] data_b,
    input  logic [11:0] data_c,
    input  logic [11:0] data_d,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        done
);

`ifdef SPKR_DAC_LDAC_EN
    localparam spkr_state_e ST_AFTER_LAST = ST_LDAC;
`else
    localparam spkr_state_e ST_AFTER_LAST = ST_FIN;
`endif

    spkr_state_e                    state_r;
    spkr_state_e                    state_s;
    logic [1:0]                     ch_r;
    logic [15:0]                    cnt_r;
    logic [3:0][SPKR_SAMPLE_W-1:0]  hold_r;
    logic                           cs_n_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           load_s;
    logic                           frame_done_s;
    logic                           gap_end_s;
    logic                           ldac_end_s;
    logic [SPKR_FRAME_W-1:0]        frame_s;

    assign load_s     = (state_r == ST_LOAD);
    assign frame_s    = spkr_frame(ch_r, hold_r[ch_r]);
    assign gap_end_s  = (cnt_r == 16'(CS_HIGH_CYCLES - 1));
    assign ldac_end_s = (cnt_r == 16'(LDAC_CYCLES - 1));

    assign cs_n = cs_n_r;
    assign busy = busy_r;
    assign done = done_r;

    spkr_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .frame      (frame_s),
        .sclk       (sclk),
        .mosi       (mosi),
        .frame_done (frame_done_s)
    );

    // Sequencing: one LOAD/SHIFT/GAP pass per channel, then optional LDAC, then FIN
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_s = ST_LOAD; else state_s = ST_IDLE;
            ST_LOAD:  state_s = ST_SHIFT;
            ST_SHIFT: if (frame_done_s) state_s = ST_GAP; else state_s = ST_SHIFT;
            ST_GAP: begin
                if (!gap_end_s)              state_s = ST_GAP;
                else if (ch_r != SPKR_CH_D)  state_s = ST_LOAD;
                else                         state_s = ST_AFTER_LAST;
            end
            ST_LDAC:  if (ldac_end_s) state_s = ST_FIN; else state_s = ST_LDAC;
            ST_FIN:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Per-state cycle counter, channel index and sample holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 16'd0;
            ch_r   <= SPKR_CH_A;
            hold_r <= '0;
        end else begin
            cnt_r <= (state_s != state_r) ? 16'd0 : cnt_r + 16'd1;
            // samples are captured only on acceptance, so inputs may change freely while busy
            if ((state_r == ST_IDLE) && start) begin
                hold_r <= {data_d, data_c, data_b, data_a};
            end
            if (state_r == ST_FIN) begin
                ch_r <= SPKR_CH_A;
            end else if ((state_r == ST_GAP) && gap_end_s && (ch_r != SPKR_CH_D)) begin
                ch_r <= ch_r + 2'd1;
            end
        end
    end

    // Registered strobes decoded from the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_r <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cs_n_r <= !((state_r == ST_LOAD) || (state_r == ST_SHIFT));
            busy_r <= (state_r == ST_LOAD) || (state_r == ST_SHIFT) ||
                      (state_r == ST_GAP)  || (state_r == ST_LDAC);
            done_r <= (state_r == ST_FIN);
        end
    end

`ifdef SPKR_DAC_LDAC_EN
    logic ldac_n_r;

    // LDAC strobe, same one-cycle registration as the other strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ldac_n_r <= 1'b1;
        end else begin
            ldac_n_r <= (state_r != ST_LDAC);
        end
    end

    assign ldac_n = ldac_n_r;
`else
    assign ldac_n = 1'b1;
`endif

endmodule
